control_convertidor: RTL and testbench
======================================

CONTROL_CONVERTIDOR -- requirements
Module: control_convertidor

Interface
REQ-001 Parameter IDLE_BYTE, default 8'hBC, byte driven on out_8 when no word is being emitted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enb  input  1  block enable; gates acceptance of new words.
REQ-005 modo  input  1  1 forces 32-bit width regardless of pclk_sel.
REQ-006 pclk_sel  input  2  width select: 00=32-bit, 01=16-bit, 10=8-bit, 11=8-bit.
REQ-007 in_data  input  32  parallel word from PCS side.
REQ-008 in_valid  input  1  in_data holds a valid word.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_8  output  8  serialized byte lane.
REQ-011 out_valid  output  1  out_8 carries a data byte.
REQ-012 out_k  output  1  out_8 carries IDLE_BYTE.
REQ-013 busy  output  1  a word is being emitted (state != IDLE).

Function
REQ-014 A word SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-015 Width SHALL be latched at acceptance: modo=1 -> 32-bit, else per pclk_sel; width changes during a word SHALL be ignored.
REQ-016 FSM states IDLE, B3, B2, B1, B0; acceptance enters B3 (32-bit), B1 (16-bit) or B0 (8-bit).
REQ-017 Transitions: B3->B2->B1->B0, one per cycle; B0 -> next start state if a word is accepted that cycle, else IDLE.
REQ-018 In state Bn, out_8 SHALL equal latched word byte n (B3=[31:24], B0=[7:0]), out_valid=1, out_k=0; all outputs registered.
REQ-019 In IDLE, out_8=IDLE_BYTE, out_valid=0, out_k=1.
REQ-020 in_ready SHALL be enb && (state==IDLE || state==B0), combinational from state and enb.
REQ-021 Latency: word accepted at edge N SHALL produce its first byte on out_8 after edge N; back-to-back words SHALL stream with no idle byte between them.
REQ-022 Deasserting enb mid-word SHALL let the current word complete, then enter IDLE.
REQ-023 in_valid deasserted while state==B0 SHALL return the FSM to IDLE after the last byte.

Reset
REQ-024 reset SHALL force state=IDLE, out_8=IDLE_BYTE, out_valid=0, out_k=1, busy=0, latched word=0, latched width=32-bit.
REQ-025 reset asserted mid-word SHALL discard the partial word; no remaining bytes are emitted.

Configuration
REQ-026 With CTRL_CONV_STATS_EN defined: output words_sent[15:0] SHALL count words whose last byte was emitted (increment on B0 exit), wrap FFFF->0000, reset to 0.
REQ-027 Without CTRL_CONV_STATS_EN: no words_sent port and no counter logic.

Structure
REQ-028 Package control_convertidor_pkg SHALL hold the state enum, width codes (W32, W16, W8) and IDLE_BYTE default constant.
REQ-029 Byte-lane mux SHALL be a sub-module selector_byte (latched word + state -> byte); FSM and handshake stay in control_convertidor.

Verification
REQ-030 32-bit: modo=0, pclk_sel=00, one word 32'hA1B2C3D4 -> out_8 A1,B2,C3,D4 on 4 consecutive cycles, then BC with out_k=1.
REQ-031 16-bit back-to-back: pclk_sel=01, words 32'h00001122 then 32'h00003344 held valid -> 11,22,33,44 with no BC between; in_ready high only in IDLE/B0.
REQ-032 modo override: modo=1, pclk_sel=10, word 32'hDEADBEEF -> DE,AD,BE,EF.
REQ-033 Width change mid-word: accept 32'h01020304 at 32-bit, switch pclk_sel to 10 on second byte -> 01,02,03,04 unchanged; next word uses 8-bit.
REQ-034 Reset after byte 2 of 32'hCAFEF00D -> out_8=BC, out_k=1, busy=0 immediately; FE's successors never appear.
REQ-035 With CTRL_CONV_STATS_EN, 65537 8-bit words -> words_sent=0001 after wrap.

Source files
------------

// File: rtl/control_convertidor_pkg.sv
// control_convertidor_pkg: shared types and constants for the PCS-to-byte
// serialiser.
//   state_t           : FSM states (IDLE, then byte lanes B3..B0)
//   width_t           : latched word width codes W32 / W16 / W8
//   IDLE_BYTE_DEFAULT : default filler byte sent when no word is active
//   width_of()        : width select decode (modo overrides pclk_sel)
//   start_state()     : first byte lane emitted for a given width
package control_convertidor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    B3,
    B2,
    B1,
    B0
  } state_t;

  typedef enum logic [1:0] {
    W32 = 2'b00,
    W16 = 2'b01,
    W8  = 2'b10
  } width_t;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hBC;

  function automatic width_t width_of(input logic modo, input logic [1:0] pclk_sel);
    width_t w;
    if (modo) begin
      w = W32;
    end else begin
      case (pclk_sel)
        2'b00:   w = W32;
        2'b01:   w = W16;
        default: w = W8;
      endcase
    end
    return w;
  endfunction

  function automatic state_t start_state(input width_t w);
    state_t s;
    case (w)
      W32:     s = B3;
      W16:     s = B1;
      default: s = B0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_convertidor_selector_byte.sv
// selector_byte: byte-lane multiplexer.
//   word  : latched 32-bit word
//   state : current FSM state; Bn selects byte n (B3 = [31:24], B0 = [7:0])
//   lane  : selected byte, or IDLE_BYTE when state is IDLE
module selector_byte
  import control_convertidor_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic [31:0] word,
  input  state_t      state,
  output logic [7:0]  lane
);

  always_comb begin
    lane = IDLE_BYTE;
    case (state)
      B3:      lane = word[31:24];
      B2:      lane = word[23:16];
      B1:      lane = word[15:8];
      B0:      lane = word[7:0];
      default: lane = IDLE_BYTE;
    endcase
  end

endmodule

// File: rtl/control_convertidor.sv
// control_convertidor: serialises 32/16/8-bit PCS words onto an 8-bit lane.
//   clk, reset          : clock, asynchronous active-high reset
//   enb                 : enable; gates acceptance of new words
//   modo, pclk_sel      : width select (modo=1 forces 32-bit)
//   in_data, in_valid   : parallel word and its valid flag
//   in_ready            : word accepted on this edge if in_valid is high
//   out_8, out_valid    : registered byte lane and data flag
//   out_k               : out_8 carries IDLE_BYTE
//   busy                : a word is being emitted
//   words_sent          : completed word counter, present only when
//                         CTRL_CONV_STATS_EN is defined
module control_convertidor
  import control_convertidor_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enb,
  input  logic        modo,
  input  logic [1:0]  pclk_sel,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_8,
  output logic        out_valid,
  output logic        out_k,
  output logic        busy
`ifdef CTRL_CONV_STATS_EN
  ,
  output logic [15:0] words_sent
`endif
);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  width_t      width_q, width_d;
  logic        accept;
  logic [7:0]  lane_d;

  assign in_ready = enb && (state_q == IDLE || state_q == B0);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    width_d = width_q;
    case (state_q)
      B3:      state_d = B2;
      B2:      state_d = B1;
      B1:      state_d = B0;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      word_d  = in_data;
      width_d = width_of(modo, pclk_sel);
      state_d = start_state(width_d);
    end
  end

  // Lane mux is fed the next state/word so the registered byte lines up
  // with the state it belongs to, one edge after acceptance.
  selector_byte #(
    .IDLE_BYTE(IDLE_BYTE)
  ) u_selector_byte (
    .word (word_d),
    .state(state_d),
    .lane (lane_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      width_q   <= W32;
      out_8     <= IDLE_BYTE;
      out_valid <= 1'b0;
      out_k     <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      width_q   <= width_d;
      out_8     <= lane_d;
      out_valid <= (state_d != IDLE);
      out_k     <= (state_d == IDLE);
    end
  end

  // The latched width is implied by the start state; keep them consistent.
  always_comb begin
    if (!reset) begin
      assert (!((state_q == B3 || state_q == B2) && width_q != W32)
              && !(state_q == B1 && width_q == W8));
    end
  end

`ifdef CTRL_CONV_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_sent <= '0;
    end else if (state_q == B0) begin
      words_sent <= words_sent + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_convertidor.sv
module tb_control_convertidor;

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic        modo;
  logic [1:0]  pclk_sel;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_8;
  logic        out_valid;
  logic        out_k;
  logic        busy;
`ifdef CTRL_CONV_STATS_EN
  logic [15:0] words_sent;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  control_convertidor #(
    .IDLE_BYTE(8'hBC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enb      (enb),
    .modo     (modo),
    .pclk_sel (pclk_sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_8    (out_8),
    .out_valid(out_valid),
    .out_k    (out_k),
    .busy     (busy)
`ifdef CTRL_CONV_STATS_EN
    ,
    .words_sent(words_sent)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        enb;
    logic        modo;
    logic [1:0]  sel;
    logic        vld;
    logic [31:0] data;
    logic        rdy;
    logic [7:0]  o8;
    logic        ov;
    logic        ok;
    logic        bsy;
  } vec_t;

  vec_t tv[28];

  logic [7:0] pend[$];
  logic [7:0] exp8;
  logic       expv;
  int         nb;

  initial begin
    // enb modo sel vld data | rdy out_8 out_valid out_k busy
    tv[0]  = '{1, 0, 2'd0, 1, 32'hA1B2C3D4, 1, 8'hA1, 1, 0, 1};
    tv[1]  = '{1, 0, 2'd0, 0, 32'h0,        0, 8'hB2, 1, 0, 1};
    tv[2]  = '{1, 0, 2'd0, 0, 32'h0,        0, 8'hC3, 1, 0, 1};
    tv[3]  = '{1, 0, 2'd0, 0, 32'h0,        0, 8'hD4, 1, 0, 1};
    tv[4]  = '{1, 0, 2'd0, 0, 32'h0,        1, 8'hBC, 0, 1, 0};
    tv[5]  = '{1, 0, 2'd0, 0, 32'h0,        1, 8'hBC, 0, 1, 0};
    tv[6]  = '{1, 0, 2'd1, 1, 32'h00001122, 1, 8'h11, 1, 0, 1};
    tv[7]  = '{1, 0, 2'd1, 1, 32'h00003344, 0, 8'h22, 1, 0, 1};
    tv[8]  = '{1, 0, 2'd1, 1, 32'h00003344, 1, 8'h33, 1, 0, 1};
    tv[9]  = '{1, 0, 2'd1, 0, 32'h0,        0, 8'h44, 1, 0, 1};
    tv[10] = '{1, 0, 2'd1, 0, 32'h0,        1, 8'hBC, 0, 1, 0};
    tv[11] = '{1, 1, 2'd2, 1, 32'hDEADBEEF, 1, 8'hDE, 1, 0, 1};
    tv[12] = '{1, 1, 2'd2, 0, 32'h0,        0, 8'hAD, 1, 0, 1};
    tv[13] = '{1, 1, 2'd2, 0, 32'h0,        0, 8'hBE, 1, 0, 1};
    tv[14] = '{1, 1, 2'd2, 0, 32'h0,        0, 8'hEF, 1, 0, 1};
    tv[15] = '{1, 1, 2'd2, 0, 32'h0,        1, 8'hBC, 0, 1, 0};
    tv[16] = '{1, 0, 2'd0, 1, 32'h01020304, 1, 8'h01, 1, 0, 1};
    tv[17] = '{1, 0, 2'd2, 0, 32'h0,        0, 8'h02, 1, 0, 1};
    tv[18] = '{1, 0, 2'd2, 0, 32'h0,        0, 8'h03, 1, 0, 1};
    tv[19] = '{1, 0, 2'd2, 0, 32'h0,        0, 8'h04, 1, 0, 1};
    tv[20] = '{1, 0, 2'd2, 1, 32'h000000AA, 1, 8'hAA, 1, 0, 1};
    tv[21] = '{1, 0, 2'd2, 0, 32'h0,        1, 8'hBC, 0, 1, 0};
    tv[22] = '{1, 0, 2'd0, 1, 32'h11223344, 1, 8'h11, 1, 0, 1};
    tv[23] = '{0, 0, 2'd0, 1, 32'h11223344, 0, 8'h22, 1, 0, 1};
    tv[24] = '{0, 0, 2'd0, 1, 32'h11223344, 0, 8'h33, 1, 0, 1};
    tv[25] = '{0, 0, 2'd0, 1, 32'h11223344, 0, 8'h44, 1, 0, 1};
    tv[26] = '{0, 0, 2'd0, 1, 32'h11223344, 0, 8'hBC, 0, 1, 0};
    tv[27] = '{1, 0, 2'd0, 0, 32'h0,        1, 8'hBC, 0, 1, 0};

    reset    = 1'b1;
    enb      = 1'b0;
    modo     = 1'b0;
    pclk_sel = 2'd0;
    in_data  = '0;
    in_valid = 1'b0;
    #3;
    chk("reset out_8", out_8, 8'hBC);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_k", out_k, 1);
    chk("reset busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      enb = tv[i].enb; modo = tv[i].modo; pclk_sel = tv[i].sel;
      in_valid = tv[i].vld; in_data = tv[i].data;
      #1;
      chk($sformatf("vec%0d in_ready", i), in_ready, tv[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out_8", i), out_8, tv[i].o8);
      chk($sformatf("vec%0d out_valid", i), out_valid, tv[i].ov);
      chk($sformatf("vec%0d out_k", i), out_k, tv[i].ok);
      chk($sformatf("vec%0d busy", i), busy, tv[i].bsy);
    end

    // Asynchronous reset after the second byte of a 32-bit word.
    @(negedge clk);
    enb = 1'b1; modo = 1'b0; pclk_sel = 2'd0; in_valid = 1'b1; in_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rst_mid byte0", out_8, 8'hCA);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid byte1", out_8, 8'hFE);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid out_8", out_8, 8'hBC);
    chk("rst_mid out_k", out_k, 1);
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_after%0d out_8", i), out_8, 8'hBC);
      chk($sformatf("rst_after%0d out_valid", i), out_valid, 0);
    end

    // Randomized traffic against a byte-queue reference model.
    pend.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      enb      = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      modo     = ($urandom_range(0, 3) == 0);
      pclk_sel = 2'($urandom_range(0, 3));
      in_data  = $urandom;
      #1;
      chk($sformatf("rnd%0d in_ready", c), in_ready, (enb && pend.size() == 0));
      @(posedge clk);
      if (enb && in_valid && pend.size() == 0) begin
        nb = modo ? 4 : (pclk_sel == 2'd0 ? 4 : (pclk_sel == 2'd1 ? 2 : 1));
        for (int b = nb - 1; b >= 0; b--) pend.push_back(in_data[8*b +: 8]);
      end
      if (pend.size() > 0) begin
        exp8 = pend.pop_front();
        expv = 1'b1;
      end else begin
        exp8 = 8'hBC;
        expv = 1'b0;
      end
      #1;
      chk($sformatf("rnd%0d out_8", c), out_8, exp8);
      chk($sformatf("rnd%0d out_valid", c), out_valid, expv);
      chk($sformatf("rnd%0d out_k", c), out_k, !expv);
      chk($sformatf("rnd%0d busy", c), busy, expv);
    end

`ifdef CTRL_CONV_STATS_EN
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("stats reset", words_sent, 0);
    @(negedge clk);
    reset = 1'b0; enb = 1'b1; modo = 1'b0; pclk_sel = 2'd2; in_valid = 1'b1;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stats wrap", words_sent, 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
